// File: rtl/add16_pkg.sv
// ============================================================================
// Module   : add16_pkg
// Brief    : Shared types and constants for the add16 streaming stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package add16_pkg;

    localparam int ADD_W        = 16;
    localparam int c_slice_w    = 4;
    localparam int c_num_slices = ADD_W / c_slice_w;

    typedef logic [ADD_W-1:0] operand_t;
    typedef logic [ADD_W:0]   result_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        logic     acc;
    } s1_t;

    // One ripple slice: returns {carry_out, sum[c_slice_w-1:0]}.
    function automatic logic [c_slice_w:0] slice_add(
        input logic [c_slice_w-1:0] a,
        input logic [c_slice_w-1:0] b,
        input logic                 cin
    );
        slice_add = {1'b0, a} + {1'b0, b} + {{c_slice_w{1'b0}}, cin};
    endfunction

endpackage : add16_pkg

`default_nettype wire

// File: rtl/add16_adder.sv
// ============================================================================
// Module   : add16_adder
// Brief    : Combinational 16-bit adder built from four 4-bit ripple slices.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add16_adder
    import add16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] sum
);

    logic [c_num_slices:0] w_carry;
    logic [ADD_W-1:0]      w_sum;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < c_num_slices; i++) begin : g_slice
        assign {w_carry[i+1], w_sum[i*c_slice_w +: c_slice_w]} =
            slice_add(a[i*c_slice_w +: c_slice_w],
                      b[i*c_slice_w +: c_slice_w],
                      w_carry[i]);
    end

    assign sum = {w_carry[c_num_slices], w_sum};

endmodule : add16_adder

`default_nettype wire

// File: rtl/add16_result_fifo.sv
// ============================================================================
// Module   : add16_result_fifo
// Brief    : Two-entry result FIFO, 1-bit pointers and 2-bit occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add16_result_fifo
    import add16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [16:0] din,
    output logic [16:0] dout,
    output logic        full,
    output logic        empty
);

    result_t    r_mem [DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    assign full  = (r_count == 2'(DEPTH));
    assign empty = (r_count == 2'd0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage is reset too so the output reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : add16_result_fifo

`default_nettype wire

// File: rtl/add16_stream_stage.sv
// ============================================================================
// Module   : add16_stream_stage
// Brief    : valid/ready wrapper around add16_adder with a 2-entry result
//            buffer and accumulate mode. ADD16_OVF_STICKY_EN adds ovf_sticky.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add16_stream_stage
    import add16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RES_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
`ifdef ADD16_OVF_STICKY_EN
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] acc
);

    s1_t      r_s1;
    logic     r_s1_valid;
    operand_t r_acc;

    logic     w_load;
    logic     w_s1_adv;
    logic     w_pop;
    logic     w_full;
    logic     w_empty;
    operand_t w_add_b;
    result_t  w_sum;

    assign w_pop     = out_valid & out_ready;
    assign w_s1_adv  = r_s1_valid & (!w_full | w_pop);
    assign in_ready  = !r_s1_valid | w_s1_adv;
    assign w_load    = in_valid & in_ready;
    assign out_valid = !w_empty;
    assign acc       = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_load) begin
            r_s1       <= '{a: in_a, b: in_b, acc: in_acc};
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // acc is read and rewritten on the same edge stage 1 advances, so a
    // following accumulate op always sees the freshly updated total.
    assign w_add_b = r_s1.acc ? r_acc : r_s1.b;

    add16_adder u_adder (
        .a   (r_s1.a),
        .b   (w_add_b),
        .sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr_acc) begin
            r_acc <= '0;
        end else if (w_s1_adv && r_s1.acc) begin
            r_acc <= w_sum[ADD_W-1:0];
        end
    end

    add16_result_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_s1_adv),
        .pop   (w_pop),
        .din   (w_sum),
        .dout  (out_sum),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef ADD16_OVF_STICKY_EN
    logic r_ovf_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (clr_acc) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_s1_adv && w_sum[ADD_W]) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

endmodule : add16_stream_stage

`default_nettype wire

// File: tb/tb_add16_stream_stage.sv
// ============================================================================
// Module   : tb_add16_stream_stage
// Brief    : Scoreboard bench for add16_stream_stage (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_add16_stream_stage;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_acc    = 1'b0;
    logic        clr_acc   = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a      = '0;
    logic [15:0] in_b      = '0;
    logic        in_ready;
    logic        out_valid;
    logic [16:0] out_sum;
    logic [15:0] acc;
`ifdef ADD16_OVF_STICKY_EN
    logic        ovf_sticky;
`endif

    add16_stream_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .clr_acc   (clr_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef ADD16_OVF_STICKY_EN
        .ovf_sticky(ovf_sticky),
`endif
        .acc       (acc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          rmode = 0;   // 0: ready high, 1: ready low, 2: random
    logic [16:0] exp_q[$];
    logic [15:0] m_acc    = '0;
    logic        m_sticky = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: operations retire in order; an accumulate op uses the
    // running total left by earlier accumulate ops.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic acc_op);
        logic [16:0] s;
        logic [15:0] beff;
        int          w;
        bit          done;
        w = 0;
        done = 0;
        in_a = a; in_b = b; in_acc = acc_op; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                beff = acc_op ? m_acc : b;
                s = {1'b0, a} + {1'b0, beff};
                if (acc_op) m_acc = s[15:0];
                if (s[16]) m_sticky = 1'b1;
                exp_q.push_back(s);
                done = 1;
            end else if (++w > 200) begin
                fail_now("send_timeout");
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            cyc(1);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_acc();
        clr_acc = 1'b1;
        cyc(1);
        clr_acc = 1'b0;
        m_acc = '0;
        m_sticky = 1'b0;
    endtask

    task automatic set_mode(input int m);
        rmode = m;
        if (m == 0) out_ready = 1'b1;
        if (m == 1) out_ready = 1'b0;
    endtask

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit          stalled;
        logic [16:0] prev_sum;
        stalled = 0;
        prev_sum = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", out_sum, prev_sum);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h expected none", out_sum);
                end else begin
                    check("out_sum", out_sum, exp_q.pop_front());
                end
                n_out++;
            end
            stalled = out_valid && !out_ready;
            prev_sum = out_sum;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          base;
        logic [15:0] a4, b4;

        // Reset state
        cyc(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_acc", acc, 0);
`ifdef ADD16_OVF_STICKY_EN
        check("rst_sticky", ovf_sticky, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("rst_in_ready", in_ready, 1);

        // 1: latency of one cycle after acceptance
        set_mode(0);
        send(16'h0001, 16'h0002, 1'b0);
        @(negedge clk);
        check("lat_pre_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_sum", out_sum, 17'h00003);
        wait_drain();
`ifdef ADD16_OVF_STICKY_EN
        check("t1_sticky", ovf_sticky, 0);
`endif

        // 2: carry out, then clear
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_drain();
`ifdef ADD16_OVF_STICKY_EN
        check("t2_sticky_set", ovf_sticky, 1);
`endif
        clear_acc();
        cyc(1);
        check("t2_acc_clr", acc, 0);
`ifdef ADD16_OVF_STICKY_EN
        check("t2_sticky_clr", ovf_sticky, 0);
`endif

        // 3: back-to-back accumulate
        send(16'h0010, 16'($urandom), 1'b1);
        send(16'h0020, 16'($urandom), 1'b1);
        send(16'h0030, 16'($urandom), 1'b1);
        wait_drain();
        check("t3_acc", acc, 16'h0060);

        // 4: back-pressure with 4 pairs
        set_mode(1);
        cyc(1);
        base = n_out;
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b0);
        a4 = 16'($urandom);
        b4 = 16'($urandom);
        in_a = a4; in_b = b4; in_acc = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_in_ready", in_ready, 0);
            check("t4_out_valid", out_valid, 1);
            check("t4_head", out_sum, exp_q[0]);
        end
        @(posedge clk);
        #1;
        set_mode(0);
        send(a4, b4, 1'b0);
        wait_drain();
        check("t4_count", n_out - base, 4);

        // 5: random stream with random back-pressure
        set_mode(2);
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        wait_drain();
        check("t5_count", n_out - base, 100);
        check("t5_acc", acc, m_acc);
`ifdef ADD16_OVF_STICKY_EN
        check("t5_sticky", ovf_sticky, m_sticky);
`endif

        // 6: reset with the buffer full
        set_mode(1);
        cyc(1);
        for (int i = 0; i < 3; i++) send(16'($urandom_range(1, 255)), 16'h0, 1'b1);
        @(negedge clk);
        check("t6_full_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_acc", acc, 0);
        exp_q.delete();
        m_acc = '0;
        m_sticky = 1'b0;
        base = n_out;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        set_mode(0);
        cyc(6);
        check("t6_no_stale", n_out - base, 0);
        check("t6_out_valid", out_valid, 0);
        send(16'h1234, 16'h4321, 1'b0);
        wait_drain();
        check("t6_after", n_out - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_add16_stream_stage

`default_nettype wire
